// File: rtl/conv_bias_add.sv
// Per-frame bias loader plus biased rescale/saturate stage between conv accumulators and the next layer.
// Define BIAS_ADD_RELU_EN to clamp negative results to zero (fused ReLU) with no extra latency.
module conv_bias_add #(
   parameter int KERN_S      = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int DATA_WIDTH  = 16,
   parameter int OUT_SHIFT   = 8,
   parameter int FRAME_LEN   = 1024
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic [COEFF_WIDTH-1:0] bias_V_dout,
   input  logic                   bias_V_empty_n,
   output logic                   bias_V_read,
   input  logic [ACC_WIDTH-1:0]   acc_V_dout,
   input  logic                   acc_V_empty_n,
   output logic                   acc_V_read,
   output logic [DATA_WIDTH-1:0]  output_V_din,
   input  logic                   output_V_full_n,
   output logic                   output_V_write,
   output logic                   frame_done
);

   localparam int IDX_W = (KERN_S > 1) ? $clog2(KERN_S) : 1;
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KERN_S - 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
   localparam logic signed [ACC_WIDTH:0] SAT_MAX =
      {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_MIN =
      {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic {LOAD, RUN} state_t;

   state_t                  state;
   logic [COEFF_WIDTH-1:0]  bank [KERN_S];
   logic [IDX_W-1:0]        load_idx;
   logic [IDX_W-1:0]        ch_idx;
   logic [CNT_W-1:0]        out_cnt;
   logic [CNT_W-1:0]        rd_cnt;
   logic                    out_valid;
   logic [COEFF_WIDTH-1:0]  cur_bias;
   logic signed [ACC_WIDTH:0] sum;
   logic signed [ACC_WIDTH:0] res;
   logic [DATA_WIDTH-1:0]   sat;

   // Stream pops are masked while reset is held so no upstream word is dropped.
   assign bias_V_read    = ~ap_rst & (state == LOAD) & bias_V_empty_n;
   assign acc_V_read     = ~ap_rst & (state == RUN) & acc_V_empty_n &
                           (~out_valid | output_V_full_n) & (rd_cnt != FRAME_CNT);
   assign output_V_write = out_valid & output_V_full_n;
   assign frame_done     = output_V_write & (out_cnt == LAST_CNT);
   assign cur_bias       = bank[ch_idx];

   always_comb begin
      sum = $signed({acc_V_dout[ACC_WIDTH-1], acc_V_dout}) +
            $signed({{(ACC_WIDTH + 1 - COEFF_WIDTH){cur_bias[COEFF_WIDTH-1]}}, cur_bias});
      res = sum >>> OUT_SHIFT;
      sat = res[DATA_WIDTH-1:0];
      if (res > SAT_MAX) begin
         sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      end else if (res < SAT_MIN) begin
         sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      end
`ifdef BIAS_ADD_RELU_EN
      if (sat[DATA_WIDTH-1]) begin
         sat = '0;
      end
`endif
   end

   // Coefficients carry no reset; they are always rewritten before RUN.
   always_ff @(posedge ap_clk) begin
      if (bias_V_read) begin
         bank[load_idx] <= bias_V_dout;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state        <= LOAD;
         load_idx     <= '0;
         ch_idx       <= '0;
         out_cnt      <= '0;
         rd_cnt       <= '0;
         out_valid    <= 1'b0;
         output_V_din <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (bias_V_read) begin
                  if (load_idx == LAST_IDX) begin
                     load_idx <= '0;
                     state    <= RUN;
                  end else begin
                     load_idx <= load_idx + 1'b1;
                  end
               end
            end
            RUN: begin
               if (frame_done) begin
                  state  <= LOAD;
                  rd_cnt <= '0;
               end
            end
            default: state <= LOAD;
         endcase

         // A read in the same cycle as a write refills the output register.
         if (acc_V_read) begin
            output_V_din <= sat;
            out_valid    <= 1'b1;
            ch_idx       <= (ch_idx == LAST_IDX) ? '0 : ch_idx + 1'b1;
            rd_cnt       <= rd_cnt + 1'b1;
         end else if (output_V_write) begin
            out_valid <= 1'b0;
         end

         if (output_V_write) begin
            out_cnt <= (out_cnt == LAST_CNT) ? '0 : out_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv_bias_add.sv
// Scoreboard bench for conv_bias_add: two instances (OUT_SHIFT 0 and 8) share one stimulus stream.
// Expected values follow BIAS_ADD_RELU_EN when the bench is built with it.
module tb_conv_bias_add;

   typedef struct packed {
      logic [15:0] d0;
      logic [15:0] d1;
      logic        last;
   } exp_t;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [15:0] bias_dout;
   logic        bias_empty_n;
   logic [31:0] acc_dout;
   logic        acc_empty_n;
   logic        full_n;

   logic        br0, br1, ar0, ar1, wr0, wr1, fd0, fd1;
   logic [15:0] din0, din1;

   logic [15:0] bias_q [$];
   logic [31:0] acc_q [$];
   exp_t        exp_q [$];
   int          push_idx = 0;
   int          wr_count = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 ap_clk = ~ap_clk;

   conv_bias_add #(
      .KERN_S(4), .COEFF_WIDTH(16), .ACC_WIDTH(32), .DATA_WIDTH(16),
      .OUT_SHIFT(0), .FRAME_LEN(8)
   ) dut0 (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(br0),
      .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(ar0),
      .output_V_din(din0), .output_V_full_n(full_n), .output_V_write(wr0),
      .frame_done(fd0)
   );

   conv_bias_add #(
      .KERN_S(4), .COEFF_WIDTH(16), .ACC_WIDTH(32), .DATA_WIDTH(16),
      .OUT_SHIFT(8), .FRAME_LEN(8)
   ) dut1 (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .bias_V_dout(bias_dout), .bias_V_empty_n(bias_empty_n), .bias_V_read(br1),
      .acc_V_dout(acc_dout), .acc_V_empty_n(acc_empty_n), .acc_V_read(ar1),
      .output_V_din(din1), .output_V_full_n(full_n), .output_V_write(wr1),
      .frame_done(fd1)
   );

   function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef BIAS_ADD_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic loadBias(input logic [15:0] b);
      bias_q.push_back(b);
   endtask

   // e0/e1 are the hand-computed signed results for OUT_SHIFT 0 and 8.
   task automatic applyStimulus(input logic [31:0] acc, input logic [15:0] e0, input logic [15:0] e1);
      exp_t e;
      acc_q.push_back(acc);
      e.d0   = relu(e0);
      e.d1   = relu(e1);
      e.last = ((push_idx % 8) == 7);
      exp_q.push_back(e);
      push_idx++;
   endtask

   task automatic waitWrites(input int n);
      int cyc;
      cyc = 0;
      while (wr_count < n && cyc < 300) begin
         @(posedge ap_clk);
         cyc++;
      end
      if (wr_count < n) checkOutput("write_timeout", wr_count, n);
   endtask

   task automatic expectNoAccRead(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge ap_clk);
         checkOutput(name, ar0, 0);
      end
   endtask

   // FIFO model: pops sampled mid-cycle, data advanced just after the edge.
   initial begin
      logic pop_b, pop_a;
      bias_empty_n = 1'b0;
      acc_empty_n  = 1'b0;
      bias_dout    = '0;
      acc_dout     = '0;
      forever begin
         @(negedge ap_clk);
         pop_b = br0;
         pop_a = ar0;
         @(posedge ap_clk);
         #1;
         if (pop_b && bias_q.size() > 0) void'(bias_q.pop_front());
         if (pop_a && acc_q.size() > 0) void'(acc_q.pop_front());
         bias_empty_n = (bias_q.size() > 0);
         bias_dout    = (bias_q.size() > 0) ? bias_q[0] : 16'h0;
         acc_empty_n  = (acc_q.size() > 0);
         acc_dout     = (acc_q.size() > 0) ? acc_q[0] : 32'h0;
      end
   end

   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst) begin
         if (wr1 !== wr0 || ar1 !== ar0 || br1 !== br0 || fd1 !== fd0)
            checkOutput("dut_pair_handshake", {28'h0, wr1, ar1, br1, fd1}, {28'h0, wr0, ar0, br0, fd0});
         if (wr0) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_write", {16'h0, din0}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               checkOutput("din_shift0", {16'h0, din0}, {16'h0, e.d0});
               checkOutput("din_shift8", {16'h0, din1}, {16'h0, e.d1});
               checkOutput("frame_done", {31'h0, fd0}, {31'h0, e.last});
            end
            wr_count++;
         end else if (fd0 !== 1'b0) begin
            checkOutput("frame_done_idle", {31'h0, fd0}, 0);
         end
      end
   end

   initial begin
      logic [15:0] held;
      ap_rst = 1'b1;
      full_n = 1'b1;
      @(negedge ap_clk);
      checkOutput("rst_write", wr0, 0);
      checkOutput("rst_din", din0, 0);
      checkOutput("rst_acc_read", ar0, 0);
      checkOutput("rst_bias_read", br0, 0);
      checkOutput("rst_frame_done", fd0, 0);
      @(posedge ap_clk);
      #3 ap_rst = 1'b0;
      @(negedge ap_clk);
      checkOutput("idle_write", wr0, 0);

      // Frame 1 biases {1,-2,3,-4}; frame 2 accumulators queued early to test frame gating.
      loadBias(16'd1); loadBias(-16'sd2); loadBias(16'd3); loadBias(-16'sd4);
      applyStimulus(32'd10, 16'd11, 16'd0);
      applyStimulus(32'd10, 16'd8, 16'd0);
      applyStimulus(32'd10, 16'd13, 16'd0);
      applyStimulus(32'd10, 16'd6, 16'd0);
      applyStimulus(32'd1000, 16'd1001, 16'd3);
      applyStimulus(-32'sd1000, -16'sd1002, -16'sd4);
      applyStimulus(32'd256, 16'd259, 16'd1);
      applyStimulus(-32'sd256, -16'sd260, -16'sd2);
      applyStimulus(32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF);
      applyStimulus(32'h8000_0000, 16'h8000, 16'h8000);
      applyStimulus(-32'sd100, -16'sd95, -16'sd1);
      applyStimulus(32'h0001_2345, 16'h7FFF, 16'h0123);
      applyStimulus(32'd100, 16'h7FFF, 16'd128);
      applyStimulus(-32'sd1, 16'h8000, -16'sd129);
      applyStimulus(32'd1000, 16'd1005, 16'd3);
      applyStimulus(32'd32767, 16'd32767, 16'd127);

      waitWrites(2);
      #1 full_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         if (i == 0) held = din0;
         else checkOutput("stall_din_stable", din0, held);
         checkOutput("stall_write", wr0, 0);
         checkOutput("stall_acc_read", ar0, 0);
      end
      @(posedge ap_clk);
      #1 full_n = 1'b1;

      waitWrites(8);
      expectNoAccRead("reload_acc_gate", 5);
      loadBias(16'h7FFF); loadBias(16'h8000); loadBias(16'd5); loadBias(16'd0);
      for (int i = 0; i < 8; i++) applyStimulus(32'd1, 16'd8, 16'd0);

      waitWrites(16);
      loadBias(16'd7); loadBias(16'd7);
      expectNoAccRead("partial_load_gate", 4);
      loadBias(16'd7); loadBias(16'd7);

      // Reset lands between edges while a word is being written.
      waitWrites(19);
      @(posedge ap_clk);
      #3;
      checkOutput("pre_reset_write", wr0, 1);
      ap_rst = 1'b1;
      #1;
      checkOutput("async_rst_write", wr0, 0);
      checkOutput("async_rst_acc_read", ar0, 0);
      checkOutput("async_rst_din", din0, 0);
      bias_q.delete();
      acc_q.delete();
      exp_q.delete();
      push_idx = 0;
      @(posedge ap_clk);
      #3 ap_rst = 1'b0;
      wr_count = 0;

      applyStimulus(-32'sd5, -16'sd15, -16'sd1);
      applyStimulus(-32'sd25, -16'sd5, -16'sd1);
      applyStimulus(32'd100, 16'd70, 16'd0);
      applyStimulus(32'd0, 16'd40, 16'd0);
      applyStimulus(32'd50, 16'd40, 16'd0);
      applyStimulus(32'd50, 16'd70, 16'd0);
      applyStimulus(32'd50, 16'd20, 16'd0);
      applyStimulus(32'd50, 16'd90, 16'd0);
      expectNoAccRead("post_reset_acc_gate", 5);
      loadBias(-16'sd10); loadBias(16'd20); loadBias(-16'sd30); loadBias(16'd40);

      waitWrites(8);
      repeat (4) @(posedge ap_clk);
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("[TB] stimulus complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_bias_add.md
Name: conv_bias_add

Overview:
- Downstream consumer of the per-layer bias ROM streamer.
- Captures KERN_S bias coefficients from the bias stream into a local register bank at the start of every frame.
- Adds the matching bias to each convolution accumulator word, rescales the sum, saturates it and emits it on an ap_fifo-style output stream to the next layer.

Parameters:
- KERN_S, 16, number of output channels (bias entries per frame), >=1
- COEFF_WIDTH, 16, bias coefficient width (signed)
- ACC_WIDTH, 32, accumulator input width (signed)
- DATA_WIDTH, 16, output data width (signed)
- OUT_SHIFT, 8, arithmetic right shift applied to the biased sum
- FRAME_LEN, 1024, output words per frame (multiple of KERN_S); after this many, biases are reloaded

Ports:
- ap_clk, in, 1, clock
- ap_rst, in, 1, reset, asynchronous, active-high
- bias_V_dout, in, COEFF_WIDTH, bias stream data (first-word-fall-through)
- bias_V_empty_n, in, 1, bias stream has data
- bias_V_read, out, 1, pop bias stream
- acc_V_dout, in, ACC_WIDTH, accumulator stream data (FWFT)
- acc_V_empty_n, in, 1, accumulator stream has data
- acc_V_read, out, 1, pop accumulator stream
- output_V_din, out, DATA_WIDTH, result data
- output_V_full_n, in, 1, downstream can accept
- output_V_write, out, 1, result write strobe
- frame_done, out, 1, one-cycle pulse when the last word of a frame is written

Behaviour:
- Reset: asynchronous and active-high, applied immediately.
  - State returns to LOAD; load_idx, ch_idx and out_cnt clear to 0; out_valid clears to 0.
  - output_V_din resets to 0; output_V_write, bias_V_read, acc_V_read and frame_done reset to 0.
  - Bias bank contents are don't-care after reset.
- Reset mid-frame: any partial load or in-flight word is discarded and the block restarts with LOAD.
- State LOAD:
  - bias_V_read = bias_V_empty_n.
  - Each cycle with bias_V_read=1, bank[load_idx] <= bias_V_dout and load_idx increments.
  - When load_idx == KERN_S-1 is written, go to RUN and clear load_idx.
  - acc_V_read = 0 throughout LOAD.
- State RUN:
  - bias_V_read = 0.
  - acc_V_read = acc_V_empty_n & (!out_valid | output_V_full_n), i.e. single-stage pipeline with stall.
  - On acc_V_read:
    - sum = sext(acc_V_dout, ACC_WIDTH+1) + sext(bank[ch_idx], ACC_WIDTH+1).
    - res = sum >>> OUT_SHIFT.
    - Saturate res to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register it into output_V_din.
    - out_valid <= 1.
    - ch_idx increments and wraps KERN_S-1 -> 0.
- Output handshake:
  - output_V_write = out_valid & output_V_full_n.
  - output_V_din is held stable while out_valid=1 and output_V_full_n=0.
  - When written with no new accumulator read in the same cycle, out_valid <= 0.
  - A simultaneous write and read replaces the register in the same cycle (full throughput, 1 word/cycle).
- Latency: 1 cycle from acc_V_read to output_V_din valid.
- Frame end:
  - out_cnt counts output writes.
  - On the write with out_cnt == FRAME_LEN-1: frame_done pulses 1 cycle, out_cnt <= 0, state returns to LOAD.
  - No accumulator read may occur once FRAME_LEN reads have been issued in the frame; track reads separately (rd_cnt) and block acc_V_read at FRAME_LEN until LOAD.
- Empty inputs: stall with no state change; a bias stream empty mid-LOAD simply pauses load_idx.
- Reset values hold until the first valid input; no spurious write strobes.

Optional Feature:
- Macro: BIAS_ADD_RELU_EN.
- Defined: after saturation, negative results are replaced by 0, giving a fused ReLU. Latency is unchanged.
- Undefined: the signed saturated result passes through unmodified.

Test Plan:
- Basic add:
  - Setup: KERN_S=4, OUT_SHIFT=0, biases {1,-2,3,-4}, acc stream {10,10,10,10}, output_V_full_n=1.
  - Required: outputs {11,8,13,6} one per cycle, each 1 cycle after the corresponding acc_V_read.
- Backpressure:
  - Stimulus: hold output_V_full_n=0 for 5 cycles mid-stream.
  - Required: output_V_din stable, output_V_write=0, acc_V_read=0; no word lost or duplicated after release.
- Saturation/shift:
  - Setup: DATA_WIDTH=16, OUT_SHIFT=8, acc=0x7FFFFFFF, bias=0x7FFF.
  - Required: output 0x7FFF; acc=0x80000000, bias=0x8000 gives 0x8000.
- Frame reload:
  - Setup: FRAME_LEN=8, KERN_S=4.
  - Required: after 8 writes, frame_done pulses once and acc_V_read stays 0 until 4 new biases are read; the second frame uses the new biases.
- Async reset:
  - Stimulus: assert ap_rst between clock edges mid-RUN with out_valid=1.
  - Required: output_V_write drops immediately, the block re-enters LOAD, and the next acc word is not consumed before 4 biases load.
- ReLU build:
  - Setup: BIAS_ADD_RELU_EN defined, acc=-100, bias=5, OUT_SHIFT=0.
  - Required: output 0; without the macro, output -95.
